// File: rtl/com_tracker_if.sv
// Pixel-stream and centroid-result bundle for com_tracker.
// master = pixel source / result consumer, slave = the tracker.
interface com_tracker_if #(
   parameter int H_WIDTH = 11,
   parameter int V_WIDTH = 10
);
   localparam int COUNT_W = H_WIDTH + V_WIDTH;

   logic               pixel_valid_in;
   logic [H_WIDTH-1:0] hcount_in;
   logic [V_WIDTH-1:0] vcount_in;
   logic               mask_in;
   logic               frame_end_in;

   logic               new_com;
   logic               light_on;
   logic [H_WIDTH-1:0] x_com;
   logic [V_WIDTH-1:0] y_com;
   logic [COUNT_W-1:0] pixel_count;
   logic               busy;
   logic               overrun;

   modport master (
      output pixel_valid_in, hcount_in, vcount_in, mask_in, frame_end_in,
      input  new_com, light_on, x_com, y_com, pixel_count, busy, overrun
   );

   modport slave (
      input  pixel_valid_in, hcount_in, vcount_in, mask_in, frame_end_in,
      output new_com, light_on, x_com, y_com, pixel_count, busy, overrun
   );
endinterface

// File: rtl/com_tracker.sv
// Per-frame centroid of masked pixels via two parallel restoring dividers.
// Optional macro COM_SMOOTH_EN: publish an exponentially smoothed centroid.
module com_tracker #(
   parameter int H_WIDTH      = 11,
   parameter int V_WIDTH      = 10,
   parameter int MIN_PIXELS   = 16,
   parameter int H_RESET      = 200,
   parameter int V_RESET      = 240,
   parameter int SMOOTH_SHIFT = 2
) (
   input  logic          clk_in,
   input  logic          rst_in,
   com_tracker_if.slave  bus
);
   localparam int COUNT_W = H_WIDTH + V_WIDTH;
   localparam int Q_W     = (H_WIDTH > V_WIDTH) ? H_WIDTH : V_WIDTH;
   localparam int SX_W    = H_WIDTH + COUNT_W;
   localparam int SY_W    = V_WIDTH + COUNT_W;
   localparam int STEP_W  = $clog2(Q_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_PUBLISH} state_t;

   state_t              state, state_nxt;
   logic                start, publish, overrun_evt;
   logic                pix_hit;
   logic [SX_W-1:0]     sum_x, sum_x_nxt;
   logic [SY_W-1:0]     sum_y, sum_y_nxt;
   logic [COUNT_W-1:0]  cnt, cnt_nxt;

   logic [STEP_W-1:0]   step;
   logic [COUNT_W-1:0]  div_cnt, rem_x, rem_y;
   logic [Q_W-1:0]      q_x, q_y;
   logic [COUNT_W:0]    trial_x, trial_y;
   logic                ge_x, ge_y;

   logic                new_com, light_on, busy, overrun, light_now;
   logic [H_WIDTH-1:0]  x_com, x_upd;
   logic [V_WIDTH-1:0]  y_com, y_upd;
   logic [COUNT_W-1:0]  pixel_count;

   // A pixel arriving with frame_end_in is folded into the snapshot of the ending frame.
   assign pix_hit   = bus.pixel_valid_in && bus.mask_in;
   assign sum_x_nxt = sum_x + (pix_hit ? SX_W'(bus.hcount_in) : '0);
   assign sum_y_nxt = sum_y + (pix_hit ? SY_W'(bus.vcount_in) : '0);
   assign cnt_nxt   = cnt + (pix_hit ? COUNT_W'(1) : '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk_in) begin
      if (!rst_in || bus.frame_end_in) begin
         sum_x <= '0;
         sum_y <= '0;
         cnt   <= '0;
      end else begin
         sum_x <= sum_x_nxt;
         sum_y <= sum_y_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt   = state;
      start       = 1'b0;
      publish     = 1'b0;
      overrun_evt = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.frame_end_in) begin
               start     = 1'b1;
               state_nxt = S_DIVIDE;
            end
         end
         S_DIVIDE: begin
            overrun_evt = bus.frame_end_in;
            if (step == STEP_W'(Q_W - 1)) state_nxt = S_PUBLISH;
         end
         S_PUBLISH: begin
            overrun_evt = bus.frame_end_in;
            publish     = 1'b1;
            state_nxt   = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Remainder starts with the dividend bits above the quotient window; since
   // sum < cnt * 2^Q_W the quotient always fits in Q_W bits.
   assign trial_x = {rem_x, q_x[Q_W-1]};
   assign trial_y = {rem_y, q_y[Q_W-1]};
   assign ge_x    = trial_x >= {1'b0, div_cnt};
   assign ge_y    = trial_y >= {1'b0, div_cnt};

   // NOTE: divider registers are always loaded on start before being read,
   // so they carry no reset.
   always_ff @(posedge clk_in) begin
      if (start) begin
         div_cnt <= cnt_nxt;
         rem_x   <= COUNT_W'(sum_x_nxt[SX_W-1:Q_W]);
         rem_y   <= COUNT_W'(sum_y_nxt[SY_W-1:Q_W]);
         q_x     <= sum_x_nxt[Q_W-1:0];
         q_y     <= sum_y_nxt[Q_W-1:0];
         step    <= '0;
      end else if (state == S_DIVIDE) begin
         rem_x <= ge_x ? COUNT_W'(trial_x - {1'b0, div_cnt}) : trial_x[COUNT_W-1:0];
         rem_y <= ge_y ? COUNT_W'(trial_y - {1'b0, div_cnt}) : trial_y[COUNT_W-1:0];
         q_x   <= {q_x[Q_W-2:0], ge_x};
         q_y   <= {q_y[Q_W-2:0], ge_y};
         step  <= step + STEP_W'(1);
      end
   end

   assign light_now = div_cnt >= COUNT_W'(MIN_PIXELS);

`ifdef COM_SMOOTH_EN
   logic signed [H_WIDTH:0] dx;
   logic signed [V_WIDTH:0] dy;

   always_comb begin
      dx    = $signed({1'b0, q_x[H_WIDTH-1:0]}) - $signed({1'b0, x_com});
      dy    = $signed({1'b0, q_y[V_WIDTH-1:0]}) - $signed({1'b0, y_com});
      x_upd = x_com + H_WIDTH'(dx >>> SMOOTH_SHIFT);
      y_upd = y_com + V_WIDTH'(dy >>> SMOOTH_SHIFT);
   end
`else
   logic unused_smooth;
   assign unused_smooth = ^SMOOTH_SHIFT;

   always_comb begin
      x_upd = q_x[H_WIDTH-1:0];
      y_upd = q_y[V_WIDTH-1:0];
   end
`endif

   // A zero count yields a meaningless quotient, so it never reaches x_com/y_com.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         new_com     <= 1'b0;
         light_on    <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         x_com       <= H_WIDTH'(H_RESET);
         y_com       <= V_WIDTH'(V_RESET);
         pixel_count <= '0;
      end else begin
         new_com <= publish;
         overrun <= overrun_evt;
         busy    <= (state_nxt != S_IDLE);
         if (publish) begin
            pixel_count <= div_cnt;
            light_on    <= light_now;
            if (light_now && (div_cnt != '0)) begin
               x_com <= x_upd;
               y_com <= y_upd;
            end
         end
      end
   end

   assign bus.new_com     = new_com;
   assign bus.light_on    = light_on;
   assign bus.x_com       = x_com;
   assign bus.y_com       = y_com;
   assign bus.pixel_count = pixel_count;
   assign bus.busy        = busy;
   assign bus.overrun     = overrun;
endmodule

// File: tb/tb_com_tracker.sv
// Scoreboard bench for com_tracker: two instances (MIN_PIXELS 1 and 16) share
// one stimulus stream; a frame-level model predicts each published result.
module tb_com_tracker;
   localparam int H_W   = 11;
   localparam int V_W   = 10;
   localparam int Q_W   = 11;
   localparam int H_RST = 200;
   localparam int V_RST = 240;
   localparam int SHIFT = 2;

   typedef struct {
      int     at;
      longint cnt;
      bit     light;
      int     x;
      int     y;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst = 1'b0;
   int     cyc = 0;
   int     n_checks = 0;
   int     n_err = 0;
   bit     mon_en = 1'b0;

   exp_t   exp_q[2][$];
   int     ovr_q[2][$];
   int     mins[2] = '{1, 16};
   int     mx[2];
   int     my[2];
   longint acc_sx, acc_sy, acc_n;
   int     last_t0 = -100;
   int     busy_lo = 1;
   int     busy_hi = 0;

   com_tracker_if #(.H_WIDTH(H_W), .V_WIDTH(V_W)) bus_a ();
   com_tracker_if #(.H_WIDTH(H_W), .V_WIDTH(V_W)) bus_b ();

   com_tracker #(.H_WIDTH(H_W), .V_WIDTH(V_W), .MIN_PIXELS(1), .H_RESET(H_RST),
                 .V_RESET(V_RST), .SMOOTH_SHIFT(SHIFT))
      dut_a (.clk_in(clk), .rst_in(rst), .bus(bus_a));

   com_tracker #(.H_WIDTH(H_W), .V_WIDTH(V_W), .MIN_PIXELS(16), .H_RESET(H_RST),
                 .V_RESET(V_RST), .SMOOTH_SHIFT(SHIFT))
      dut_b (.clk_in(clk), .rst_in(rst), .bus(bus_b));

   always #5 clk = ~clk;
   // After clock edge n, cyc == n.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int smooth(int prev, int q);
      int r;
      r = q;
`ifdef COM_SMOOTH_EN
      begin
         int d;
         int s;
         d = q - prev;
         if (d >= 0) s = d / (1 << SHIFT);
         else        s = -((-d + (1 << SHIFT) - 1) / (1 << SHIFT));
         r = prev + s;
      end
`endif
      return r;
   endfunction

   // Frame-level reference: an accepted frame end at edge t publishes at t+Q_W+1.
   task automatic model(bit v, int h, int y, bit m, bit fe, int t);
      exp_t e;
      if (v && m) begin
         acc_sx += h;
         acc_sy += y;
         acc_n++;
      end
      if (fe) begin
         if (t >= last_t0 + Q_W + 2) begin
            last_t0 = t;
            busy_lo = t;
            busy_hi = t + Q_W;
            for (int i = 0; i < 2; i++) begin
               e.at    = t + Q_W + 1;
               e.cnt   = acc_n;
               e.light = (acc_n >= mins[i]);
               if (e.light && acc_n > 0) begin
                  mx[i] = smooth(mx[i], int'(acc_sx / acc_n));
                  my[i] = smooth(my[i], int'(acc_sy / acc_n));
               end
               e.x = mx[i];
               e.y = my[i];
               exp_q[i].push_back(e);
            end
         end else begin
            for (int i = 0; i < 2; i++) ovr_q[i].push_back(t);
         end
         acc_sx = 0;
         acc_sy = 0;
         acc_n  = 0;
      end
   endtask

   task automatic put(bit v, int h, int y, bit m, bit fe);
      bus_a.pixel_valid_in = v;
      bus_a.hcount_in      = h[H_W-1:0];
      bus_a.vcount_in      = y[V_W-1:0];
      bus_a.mask_in        = m;
      bus_a.frame_end_in   = fe;
      bus_b.pixel_valid_in = v;
      bus_b.hcount_in      = h[H_W-1:0];
      bus_b.vcount_in      = y[V_W-1:0];
      bus_b.mask_in        = m;
      bus_b.frame_end_in   = fe;
   endtask

   task automatic drive(bit v, int h, int y, bit m, bit fe);
      @(posedge clk);
      #1;
      put(v, h, y, m, fe);
      model(v, h, y, m, fe, cyc + 1);
   endtask

   task automatic idle(int n);
      repeat (n) drive(1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic rst_chk(string tag, logic nc, logic lo, logic [H_W-1:0] x,
                          logic [V_W-1:0] y, logic [H_W+V_W-1:0] pc, logic bz, logic ov);
      check({"rst_new_com_", tag}, nc, 0);
      check({"rst_light_on_", tag}, lo, 0);
      check({"rst_x_com_", tag}, x, H_RST);
      check({"rst_y_com_", tag}, y, V_RST);
      check({"rst_pixel_count_", tag}, pc, 0);
      check({"rst_busy_", tag}, bz, 0);
      check({"rst_overrun_", tag}, ov, 0);
   endtask

   task automatic do_reset();
      int t;
      @(posedge clk);
      #1;
      rst = 1'b0;
      put(1'b0, 0, 0, 1'b0, 1'b0);
      t = cyc + 1;
      for (int i = 0; i < 2; i++) begin
         while (exp_q[i].size() > 0 && exp_q[i][exp_q[i].size()-1].at >= t) void'(exp_q[i].pop_back());
         while (ovr_q[i].size() > 0 && ovr_q[i][ovr_q[i].size()-1] >= t) void'(ovr_q[i].pop_back());
         mx[i] = H_RST;
         my[i] = V_RST;
      end
      acc_sx  = 0;
      acc_sy  = 0;
      acc_n   = 0;
      last_t0 = -100;
      if (busy_hi >= t) busy_hi = t - 1;
      @(posedge clk);
      @(negedge clk);
      rst_chk("a", bus_a.new_com, bus_a.light_on, bus_a.x_com, bus_a.y_com,
              bus_a.pixel_count, bus_a.busy, bus_a.overrun);
      rst_chk("b", bus_b.new_com, bus_b.light_on, bus_b.x_com, bus_b.y_com,
              bus_b.pixel_count, bus_b.busy, bus_b.overrun);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic mon(int i, logic nc, logic lo, logic [H_W-1:0] x, logic [V_W-1:0] y,
                      logic [H_W+V_W-1:0] pc, logic bz, logic ov);
      exp_t  e;
      int    t;
      string tag;
      tag = (i == 0) ? "a" : "b";
      check({"busy_", tag}, bz, (cyc >= busy_lo && cyc <= busy_hi));
      if (nc !== 1'b0) begin
         if (exp_q[i].size() == 0) begin
            check({"new_com_unexpected_", tag}, nc, 0);
         end else begin
            e = exp_q[i].pop_front();
            check({"new_com_cycle_", tag}, cyc, e.at);
            check({"pixel_count_", tag}, pc, e.cnt);
            check({"light_on_", tag}, lo, e.light);
            check({"x_com_", tag}, x, e.x);
            check({"y_com_", tag}, y, e.y);
         end
      end else if (exp_q[i].size() > 0 && exp_q[i][0].at < cyc) begin
         void'(exp_q[i].pop_front());
         check({"new_com_missing_", tag}, nc, 1);
      end
      if (ov !== 1'b0) begin
         if (ovr_q[i].size() == 0) begin
            check({"overrun_unexpected_", tag}, ov, 0);
         end else begin
            t = ovr_q[i].pop_front();
            check({"overrun_cycle_", tag}, cyc, t);
         end
      end else if (ovr_q[i].size() > 0 && ovr_q[i][0] < cyc) begin
         void'(ovr_q[i].pop_front());
         check({"overrun_missing_", tag}, ov, 1);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, bus_a.new_com, bus_a.light_on, bus_a.x_com, bus_a.y_com,
             bus_a.pixel_count, bus_a.busy, bus_a.overrun);
         mon(1, bus_b.new_com, bus_b.light_on, bus_b.x_com, bus_b.y_com,
             bus_b.pixel_count, bus_b.busy, bus_b.overrun);
      end
   end

   initial begin
      int px[4] = '{10, 20, 10, 20};
      int py[4] = '{10, 10, 20, 20};
      int len;
      int gap;
      bit v;
      bit m;
      bit fe;

      put(1'b0, 0, 0, 1'b0, 1'b0);
      do_reset();
      mon_en = 1'b1;

      // Single masked pixel: instance a publishes it, instance b holds reset position.
      drive(1'b1, 100, 50, 1'b1, 1'b0);
      idle(2);
      drive(1'b0, 0, 0, 1'b0, 1'b1);
      idle(Q_W + 3);

      // Four masked corners among 100 unmasked pixels.
      for (int k = 0; k < 104; k++) begin
         if (k % 26 == 5) drive(1'b1, px[k / 26], py[k / 26], 1'b1, 1'b0);
         else drive(1'b1, $urandom_range(0, 2047), $urandom_range(0, 1023), 1'b0, 1'b0);
      end
      drive(1'b0, 0, 0, 1'b0, 1'b1);
      idle(Q_W + 3);

      // Empty frame.
      drive(1'b0, 0, 0, 1'b0, 1'b1);
      idle(Q_W + 3);

      // 15 then 16 masked pixels: the MIN_PIXELS=16 threshold edge.
      for (int n = 15; n <= 16; n++) begin
         for (int j = 0; j < n; j++)
            drive(1'b1, $urandom_range(0, 2047), $urandom_range(0, 1023), 1'b1, 1'b0);
         drive(1'b0, 0, 0, 1'b0, 1'b1);
         idle(Q_W + 3);
      end

      // Frame end at T0+5 is dropped along with its pixels.
      for (int j = 0; j < 20; j++) drive(1'b1, 300 + j, 400, 1'b1, 1'b0);
      drive(1'b0, 0, 0, 1'b0, 1'b1);
      for (int j = 0; j < 4; j++) drive(1'b1, 2000, 1000, 1'b1, 1'b0);
      drive(1'b1, 2000, 1000, 1'b1, 1'b1);
      for (int j = 0; j < 20; j++) drive(1'b1, 50 + j, 60, 1'b1, 1'b0);
      drive(1'b0, 0, 0, 1'b0, 1'b1);
      idle(Q_W + 3);

      // Frame ends at T0+Q_W+1 (dropped) and T0+Q_W+2 (accepted, carrying its own pixel).
      drive(1'b1, 700, 300, 1'b1, 1'b1);
      for (int j = 0; j < Q_W; j++) drive(1'b1, 900, 900, 1'b1, 1'b0);
      drive(1'b1, 900, 900, 1'b1, 1'b1);
      drive(1'b1, 1234, 567, 1'b1, 1'b1);
      idle(Q_W + 3);

      // Reset six cycles into a division, then a normal frame.
      for (int j = 0; j < 20; j++) drive(1'b1, 1000, 800, 1'b1, 1'b0);
      drive(1'b0, 0, 0, 1'b0, 1'b1);
      for (int j = 0; j < 5; j++) drive(1'b1, 5, 5, 1'b1, 1'b0);
      do_reset();
      for (int j = 0; j < 18; j++) drive(1'b1, 400 + j, 100 + j, 1'b1, 1'b0);
      drive(1'b0, 0, 0, 1'b0, 1'b1);
      idle(Q_W + 3);

      // Randomized frames with occasional early frame ends.
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(5, 70);
         for (int k = 0; k < len; k++) begin
            v  = ($urandom_range(0, 3) != 0);
            m  = ($urandom_range(0, 3) != 0);
            fe = ($urandom_range(0, 49) == 0);
            drive(v, $urandom_range(0, 2047), $urandom_range(0, 1023), m, fe);
         end
         v = ($urandom_range(0, 1) != 0);
         drive(v, $urandom_range(0, 2047), $urandom_range(0, 1023), 1'b1, 1'b1);
         gap = $urandom_range(0, 14);
         idle(gap);
      end

      idle(Q_W + 5);
      for (int i = 0; i < 2; i++) begin
         check("pending_new_com", exp_q[i].size(), 0);
         check("pending_overrun", ovr_q[i].size(), 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
